glb_stream_src: RTL and testbench

- Synthesizable, parametrised successor of the GLB write-side stream source used in memory-core benches.
- Holds a locally loaded word buffer and, after each flush pulse, streams a configured window of it onto a valid/ready channel.
- Supports repeat passes, address wrap and an optional end-of-stream control token.
- Sits between the GLB model/loader and a memory-core input port.

---
 rtl/glb_stream_pkg.sv | 20 ++
 rtl/glb_stream_buf.sv | 23 ++
 rtl/glb_stream_src.sv | 195 +++++++++++++++++++
 tb/tb_glb_stream_src.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_stream_pkg.sv
// Shared types and constants for the GLB write-side stream source.
package glb_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FLUSH,
    S_DELAY,
    S_STREAM,
    S_EOS,
    S_DONE
  } glb_src_state_t;

  localparam int GLB_EOS_PAYLOAD = 0;

  // The control flag sits just above the payload bits.
  function automatic int glb_ctrl_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/glb_stream_buf.sv
// Flop word buffer: one registered write port, one combinational read port.
module glb_stream_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/glb_stream_src.sv
// Streams a configured window of a local buffer onto a valid/ready channel
// after each flush pulse, with repeat passes, wrap and optional EOS token.
module glb_stream_src
  import glb_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int START_DELAY = 3,
  parameter int PASS_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [ADDR_W-1:0]     cfg_start_addr,
  input  logic [ADDR_W:0]       cfg_tx_size,
  input  logic [PASS_W-1:0]     cfg_num_passes,
  input  logic                  cfg_eos_en,
  output logic [DATA_WIDTH:0]   data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  done,
  output logic                  busy
);

  localparam int CTRL = glb_ctrl_bit(DATA_WIDTH);
  localparam int OW   = DATA_WIDTH + 1;
  localparam int TW   = ADDR_W + 1;
  localparam int DW   = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

  glb_src_state_t state, nxt;

  logic [OW-1:0]         nxt_data, eos_word;
  logic                  nxt_valid, nxt_done;
  logic [TW-1:0]         idx, nxt_idx, fetch_idx;
  logic [PASS_W-1:0]     pass, nxt_pass;
  logic [DW-1:0]         dcnt, nxt_dcnt;
  logic [ADDR_W-1:0]     sh_start, e_start, rd_addr;
  logic [TW-1:0]         sh_tx, e_tx;
  logic [PASS_W-1:0]     sh_np, e_np, cfg_np;
  logic                  sh_eos, e_eos;
  logic                  in_wf, latch, last_idx, last_pass;
  logic                  hs, go, fin;
  logic [DATA_WIDTH-1:0] rd_data;

  assign busy     = state inside {S_DELAY, S_STREAM, S_EOS};
  assign ld_ready = !busy;

  // While arming, the live config is used so a zero delay can fetch at once.
  assign in_wf   = (state == S_WAIT_FLUSH);
  assign cfg_np  = (cfg_num_passes == '0) ? PASS_W'(1) : cfg_num_passes;
  assign e_start = in_wf ? cfg_start_addr : sh_start;
  assign e_tx    = in_wf ? cfg_tx_size : sh_tx;
  assign e_np    = in_wf ? cfg_np : sh_np;
  assign e_eos   = in_wf ? cfg_eos_en : sh_eos;

  assign eos_word = {1'b1, DATA_WIDTH'(GLB_EOS_PAYLOAD)};

  assign last_idx  = (idx == e_tx - TW'(1));
  assign last_pass = (pass == e_np - PASS_W'(1));
  assign hs        = valid && ready;

  assign fetch_idx = (state == S_STREAM && !last_idx)
                   ? idx + TW'(1) : '0;
  assign rd_addr   = e_start + fetch_idx[ADDR_W-1:0];

  glb_stream_buf #(
    .W     (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (ld_valid && ld_ready),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    nxt       = state;
    nxt_data  = data;
    nxt_valid = valid;
    nxt_done  = done;
    nxt_idx   = idx;
    nxt_pass  = pass;
    nxt_dcnt  = dcnt;
    latch     = 1'b0;
    go        = 1'b0;
    fin       = 1'b0;
    if (flush) begin
      nxt       = S_WAIT_FLUSH;
      nxt_data  = '0;
      nxt_valid = 1'b0;
      nxt_done  = 1'b0;
      nxt_idx   = '0;
      nxt_pass  = '0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_WAIT_FLUSH: begin
          latch = 1'b1;
          if (START_DELAY == 0) begin
            go = 1'b1;
          end else begin
            nxt      = S_DELAY;
            nxt_dcnt = DW'(START_DELAY);
          end
        end
        S_DELAY: begin
          nxt_dcnt = dcnt - DW'(1);
          if (dcnt <= DW'(1)) go = 1'b1;
        end
        S_STREAM: begin
          if (hs) begin
            if (last_idx && last_pass) begin
              fin = 1'b1;
            end else begin
              nxt_data = {1'b0, rd_data};
              nxt_idx  = fetch_idx;
              if (last_idx) nxt_pass = pass + PASS_W'(1);
            end
          end
        end
        S_EOS: begin
          if (hs) begin
            nxt       = S_DONE;
            nxt_data  = '0;
            nxt_valid = 1'b0;
            nxt_done  = 1'b1;
          end
        end
        S_DONE: ;
        default: nxt = S_IDLE;
      endcase
      // Entry into STREAM loads the first word on the same edge.
      if (go && e_tx != '0) begin
        nxt       = S_STREAM;
        nxt_data  = {1'b0, rd_data};
        nxt_valid = 1'b1;
        nxt_idx   = '0;
        nxt_pass  = '0;
      end else if (go || fin) begin
        if (e_eos) begin
          nxt       = S_EOS;
          nxt_data  = eos_word;
          nxt_valid = 1'b1;
        end else begin
          nxt       = S_DONE;
          nxt_data  = '0;
          nxt_valid = 1'b0;
          nxt_done  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      data     <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      pass     <= '0;
      dcnt     <= '0;
      sh_start <= '0;
      sh_tx    <= '0;
      sh_np    <= '0;
      sh_eos   <= 1'b0;
    end else begin
      state <= nxt;
      data  <= nxt_data;
      valid <= nxt_valid;
      done  <= nxt_done;
      idx   <= nxt_idx;
      pass  <= nxt_pass;
      dcnt  <= nxt_dcnt;
      if (latch) begin
        sh_start <= e_start;
        sh_tx    <= e_tx;
        sh_np    <= e_np;
        sh_eos   <= e_eos;
      end
    end
  end

  logic unused_ctrl;
  assign unused_ctrl = data[CTRL];

endmodule

// File: tb/tb_glb_stream_src.sv
// Scoreboard bench for glb_stream_src: expected words are queued when a
// stream is configured and popped as the DUT hands them off.
module tb_glb_stream_src;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int SD    = 3;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] cfg_start_addr;
  logic [AW:0]   cfg_tx_size;
  logic [PW-1:0] cfg_num_passes;
  logic          cfg_eos_en;
  logic [DW:0]   data;
  logic          valid;
  logic          ready;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW:0]   q[$];
  logic [DW-1:0] mm[DEPTH];

  glb_stream_src #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .START_DELAY (SD),
    .PASS_W      (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .cfg_start_addr (cfg_start_addr),
    .cfg_tx_size    (cfg_tx_size),
    .cfg_num_passes (cfg_num_passes),
    .cfg_eos_en     (cfg_eos_en),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .done           (done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = AW'(a);
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    mm[a]    = d;
  endtask

  task automatic set_cfg(input int s, input int t, input int p,
                         input bit e);
    int np;
    cfg_start_addr = AW'(s);
    cfg_tx_size    = (AW+1)'(t);
    cfg_num_passes = PW'(p);
    cfg_eos_en     = e;
    np = (p == 0) ? 1 : p;
    q.delete();
    if (t > 0)
      for (int pp = 0; pp < np; pp++)
        for (int i = 0; i < t; i++)
          q.push_back({1'b0, mm[(s + i) % DEPTH]});
    if (e) q.push_back({1'b1, 16'h0000});
  endtask

  task automatic arm();
    flush = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic run(input bit rnd, input bit lat, input int abort_n);
    int          cyc    = 0;
    int          nhs    = 0;
    int          hs_cyc = -1;
    int          first  = -1;
    bit          hold   = 1'b0;
    logic [DW:0] hdat;
    logic [DW:0] exp;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", 32'(valid), 1);
        chk("hold_data", 32'(data), 32'(hdat));
      end
      hold = valid && !ready;
      hdat = data;
      if (valid && first < 0) begin
        first = cyc;
        if (lat) chk("first_valid_lat", first, SD + 1);
      end
      if (done) begin
        if (hs_cyc >= 0) chk("done_lat", cyc - hs_cyc, 1);
        else chk("done_nodata_lat", cyc, SD + 1);
        chk("queue_left", q.size(), 0);
        chk("done_valid", 32'(valid), 0);
        return;
      end
      if (valid && ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 32'(q.size() != 0), 1);
        end else begin
          exp = q.pop_front();
          chk($sformatf("word%0d", nhs), 32'(data), 32'(exp));
        end
        nhs++;
        hs_cyc = cyc;
        if (nhs == abort_n) begin
          @(posedge clk); #1;
          flush = 1'b1;
          @(posedge clk);
          @(negedge clk);
          chk("abort_valid", 32'(valid), 0);
          chk("abort_done", 32'(done), 0);
          return;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (rnd) ready = 1'($urandom_range(0, 1));
    end
    chk("stream_timeout", cyc, 0);
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    ld_valid       = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    cfg_start_addr = '0;
    cfg_tx_size    = '0;
    cfg_num_passes = '0;
    cfg_eos_en     = 1'b0;
    ready          = 1'b1;

    @(negedge clk);
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(valid), 0);

    for (int i = 0; i < 32; i++) load(i, 16'(16'h0100 + i));

    // Basic 32-word stream, continuous ready.
    set_cfg(0, 32, 1, 1'b0);
    arm();
    run(1'b0, 1'b1, 0);

    // Same window with random backpressure.
    set_cfg(0, 32, 1, 1'b0);
    arm();
    run(1'b1, 1'b1, 0);

    // Two passes over words 5..7 followed by EOS.
    set_cfg(5, 3, 2, 1'b1);
    arm();
    run(1'b0, 1'b1, 0);

    // Abort after 10 words, then a full restart.
    set_cfg(0, 32, 1, 1'b0);
    arm();
    run(1'b0, 1'b1, 10);
    set_cfg(0, 32, 1, 1'b0);
    arm();
    run(1'b0, 1'b1, 0);

    // Writes issued while busy must be dropped.
    set_cfg(0, 8, 1, 1'b0);
    arm();
    @(posedge clk); #1;
    chk("busy_delay", 32'(busy), 1);
    chk("ld_ready_busy", 32'(ld_ready), 0);
    ld_valid = 1'b1;
    ld_addr  = 6'd0;
    ld_data  = 16'hdead;
    @(posedge clk); #1;
    ld_addr  = 6'd1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    run(1'b0, 1'b0, 0);

    // Empty window, with and without EOS.
    set_cfg(0, 0, 1, 1'b1);
    arm();
    run(1'b0, 1'b1, 0);
    set_cfg(0, 0, 1, 1'b0);
    arm();
    run(1'b0, 1'b1, 0);

    // Address wrap across the top of the buffer.
    load(DEPTH - 2, 16'h0a0a);
    load(DEPTH - 1, 16'h0b0b);
    load(0, 16'h0c0c);
    load(1, 16'h0d0d);
    set_cfg(DEPTH - 2, 4, 1, 1'b0);
    arm();
    run(1'b1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
